// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants, arbiter state encoding and width helper
//
// Purpose: common definitions for the operator-button command scheduler.
// Ports:   none (package).

package btn_pkg;

  localparam int DEFAULT_N_BTN        = 4;
  localparam int DEFAULT_DIV          = 250000;
  localparam int DEFAULT_STABLE_TICKS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Ceiling log2, never less than 1 so it can size any vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_cmd_scheduler_if.sv
// rtl/btn_cmd_scheduler_if.sv - valid/ready command stream to the conveyor FSM
//
// Purpose: carries the serialised button commands.
// Signals:
//   cmd_valid  producer -> consumer  a command is offered
//   cmd_id     producer -> consumer  index of the offered button
//   cmd_ready  consumer -> producer  consumer accepts the current command

interface btn_cmd_scheduler_if
  import btn_pkg::*;
#(
  parameter int N_BTN = DEFAULT_N_BTN
) ();

  localparam int ID_W = clog2(N_BTN);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debouncer, press-edge detector
//
// Purpose: debounces one raw button on the shared sample tick and flags presses.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   tick     in   shared sample strobe
//   btn_raw  in   asynchronous raw level, 1 = pressed
//   level    out  debounced level
//   press    out  one-cycle pulse, the cycle after level rises

module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = clog2(STABLE_TICKS + 1);

  logic             sync_meta;
  logic             sync_s;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      press     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_s    <= sync_meta;
      level_d   <= level;
      press     <= level & ~level_d;
      // Any tick that agrees with the current level restarts the run, so
      // only an uninterrupted run of differing samples flips the level.
      if (tick) begin
        if (sync_s == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
          level <= sync_s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// rtl/btn_cmd_scheduler.sv - debounced operator buttons to prioritised command stream
//
// Purpose: sample-tick divider, N debounce channels, pending-press register and
//          fixed-priority arbiter (index 0 highest) driving a valid/ready stream.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   btn_raw    in   raw button levels
//   tick       out  one-cycle sample strobe every DIV cycles
//   btn_level  out  debounced levels
//   overflow   out  pulse: a press merged into an already-pending request
//   cmd        master side of btn_cmd_scheduler_if (cmd_valid, cmd_id, cmd_ready)

module btn_cmd_scheduler
  import btn_pkg::*;
#(
  parameter int N_BTN        = DEFAULT_N_BTN,
  parameter int DIV          = DEFAULT_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic                  tick,
  output logic [N_BTN-1:0]      btn_level,
  output logic                  overflow,
  btn_cmd_scheduler_if.master   cmd
);

  localparam int ID_W  = clog2(N_BTN);
  localparam int DIV_W = clog2(DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] clr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  lowest_idx;
  logic             load_id;
  logic             accept;
  arb_state_t       state, state_next;

  // Sample-tick divider.
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .btn_raw(btn_raw[g]),
      .level  (btn_level[g]),
      .press  (press[g])
    );
  end

  // Arbiter next state and handshake decode.
  always_comb begin
    state_next = state;
    load_id    = 1'b0;
    accept     = 1'b0;
    lowest_idx = '0;
    clr        = '0;

    // Scan downwards so the lowest set index is the one left standing.
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        lowest_idx = ID_W'(i);
      end
    end

    case (state)
      IDLE: begin
        if (pend != '0) begin
          load_id    = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (cmd.cmd_ready) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    for (int i = 0; i < N_BTN; i++) begin
      clr[i] = accept && (id_q == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Offered id is frozen for the whole OFFER state; later, higher-priority
  // presses wait for the next round.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q     <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      if (load_id) begin
        id_q <= lowest_idx;
      end
      // Set dominates clear so a press landing on its own handshake survives.
      pend     <= (pend & ~clr) | press;
      overflow <= |(press & pend & ~clr);
    end
  end

  assign cmd.cmd_valid = (state == OFFER);
  assign cmd.cmd_id    = id_q;

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// tb/tb_btn_cmd_scheduler.sv - directed self-checking bench for btn_cmd_scheduler

module tb_btn_cmd_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic       tick;
  logic [3:0] btn_level;
  logic       overflow;

  int n_cmp;
  int n_bad;
  int cyc;
  int hs_ids[$];

  btn_cmd_scheduler_if #(.N_BTN(4)) cmd_if ();

  btn_cmd_scheduler #(
    .N_BTN       (4),
    .DIV         (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .tick     (tick),
    .btn_level(btn_level),
    .overflow (overflow),
    .cmd      (cmd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1) begin
      hs_ids.push_back(int'(cmd_if.cmd_id));
    end
  end

  typedef struct {
    logic [3:0] raw;
    logic       ready;
    logic       exp_tick;
    logic       exp_valid;
    logic [3:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    btn_raw = 4'b0;
    cmd_if.cmd_ready = 1'b0;

    // Idle vectors after reset release: tick in every 4th cycle (index 3, 7, 11).
    vecs[0]  = '{4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[1]  = '{4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[2]  = '{4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[3]  = '{4'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0};
    vecs[4]  = '{4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[5]  = '{4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[6]  = '{4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[7]  = '{4'b0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0};
    vecs[8]  = '{4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[9]  = '{4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[10] = '{4'b0, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0};
    vecs[11] = '{4'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0};

    step();
    step();
    step();
    chk("rst_valid", cmd_if.cmd_valid, 1'b0);
    chk("rst_id", cmd_if.cmd_id, 2'd0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_level", btn_level, 4'b0);
    reset = 1'b0;
    cyc = 0;

    for (int v = 0; v < 12; v++) begin
      btn_raw = vecs[v].raw;
      cmd_if.cmd_ready = vecs[v].ready;
      chk("vec_tick", tick, vecs[v].exp_tick);
      chk("vec_valid", cmd_if.cmd_valid, vecs[v].exp_valid);
      chk("vec_level", btn_level, vecs[v].exp_level);
      chk("vec_ovf", overflow, vecs[v].exp_ovf);
      step();
    end
    for (int k = 12; k < 40; k++) begin
      chk("idle_tick", tick, (k % 4 == 3));
      chk("idle_valid", cmd_if.cmd_valid, 1'b0);
      step();
    end

    // Button 2 held 20 cycles: level at +12, press +13, pend +14, valid +15.
    align();
    hs_ids.delete();
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < 36; k++) begin
      btn_raw = (k < 20) ? 4'b0100 : 4'b0000;
      chk("b2_level", btn_level[2], (k >= 12 && k < 32));
      chk("b2_valid", cmd_if.cmd_valid, (k == 15));
      if (k == 15) chk("b2_id", cmd_if.cmd_id, 2'd2);
      chk("b2_ovf", overflow, 1'b0);
      step();
    end
    chk("b2_pend", dut.pend, 4'b0);
    chk("b2_hs_n", hs_ids.size(), 1);
    if (hs_ids.size() > 0) chk("b2_hs_id", hs_ids[0], 2);

    // Glitch on button 1 shorter than three ticks.
    align();
    hs_ids.delete();
    for (int k = 0; k < 24; k++) begin
      btn_raw = (k < 6) ? 4'b0010 : 4'b0000;
      chk("gl_level", btn_level, 4'b0);
      chk("gl_valid", cmd_if.cmd_valid, 1'b0);
      step();
    end
    chk("gl_hs_n", hs_ids.size(), 0);

    // Buttons 3 and 0 together, consumer stalls 10 cycles.
    align();
    hs_ids.delete();
    for (int k = 0; k < 40; k++) begin
      btn_raw = (k < 16) ? 4'b1001 : 4'b0000;
      cmd_if.cmd_ready = (k >= 25);
      chk("pr_valid", cmd_if.cmd_valid, ((k >= 15 && k <= 25) || k == 27));
      if (k >= 15 && k <= 25) chk("pr_id0", cmd_if.cmd_id, 2'd0);
      if (k == 27) chk("pr_id3", cmd_if.cmd_id, 2'd3);
      step();
    end
    chk("pr_hs_n", hs_ids.size(), 2);
    if (hs_ids.size() == 2) begin
      chk("pr_hs_first", hs_ids[0], 0);
      chk("pr_hs_second", hs_ids[1], 3);
    end

    // Button 1 pressed twice while the first request is still pending.
    align();
    hs_ids.delete();
    for (int k = 0; k < 60; k++) begin
      btn_raw = ((k < 13) || (k >= 24 && k < 37)) ? 4'b0010 : 4'b0000;
      cmd_if.cmd_ready = (k >= 40);
      chk("ov_pulse", overflow, (k == 38));
      chk("ov_valid", cmd_if.cmd_valid, (k >= 15 && k <= 40));
      if (k == 40) chk("ov_id", cmd_if.cmd_id, 2'd1);
      step();
    end
    chk("ov_hs_n", hs_ids.size(), 1);
    if (hs_ids.size() > 0) chk("ov_hs_id", hs_ids[0], 1);

    // Reset while a command for button 2 is on offer.
    align();
    hs_ids.delete();
    cmd_if.cmd_ready = 1'b0;
    btn_raw = 4'b0100;
    for (int k = 0; k < 16; k++) step();
    chk("rm_valid_pre", cmd_if.cmd_valid, 1'b1);
    chk("rm_id_pre", cmd_if.cmd_id, 2'd2);
    reset = 1'b1;
    btn_raw = 4'b0;
    step();
    chk("rm_valid", cmd_if.cmd_valid, 1'b0);
    chk("rm_pend", dut.pend, 4'b0);
    chk("rm_level", btn_level, 4'b0);
    chk("rm_ovf", overflow, 1'b0);
    chk("rm_id", cmd_if.cmd_id, 2'd0);
    reset = 1'b0;
    cyc = 0;
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      chk("rm_post_valid", cmd_if.cmd_valid, 1'b0);
      chk("rm_post_tick", tick, (k % 4 == 3));
      step();
    end
    chk("rm_hs_n", hs_ids.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
